sandpiper_7seg_scan_capture: RTL and testbench
==============================================

Name: sandpiper_7seg_scan_capture

Overview:
- Receive-side counterpart of the Sandpiper 7-segment serial driver.
- Monitors the SCLK/DOUT/RCLK/~OE lines that feed the cascaded 74HCS596 pair and reconstructs each 16-bit {CA[7:0],SEG[7:0]} word.
- Decodes the lit character index and stores segments per character in a readable frame buffer.
- Estimates per-character brightness from ~OE duty.
- Used for on-board loopback self-test and as a display-mirror input on a second FPGA.

Parameters:
- SEG_CT, 8, segment bits per word (fixed).
- CAN_CT, 8, common-anode bits per word (fixed; power of 2).
- DIMMING_STEPS, 256, brightness levels (power of 2); PWM period is 2*DIMMING_STEPS cycles.
- TIMEOUT_CYC, 4096, sys_clk cycles of SCLK inactivity that abort a partial word.
- SYNC_STAGES, 2, synchronizer depth on all four serial inputs (min 2).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable; when low, edge detection and counters are held cleared.
- SCLK_IN  in  1  serial shift clock, asynchronous.
- DOUT_IN  in  1  serial data, LSB of word first, asynchronous.
- RCLK_IN  in  1  register latch clock, asynchronous.
- OE_IN  in  1  active-low output enable, asynchronous.
- word_valid  out  1  one-cycle pulse: a good word was captured.
- word_data  out  16  last good word {CA,SEG}.
- char_idx  out  3  index of the set CA bit in the last good word.
- scan_done  out  1  one-cycle pulse when index 7 follows index 6.
- err_pulse  out  1  one-cycle pulse on any framing error.
- err_code  out  2  00 none, 01 bit count not 16, 10 CA not one-hot, 11 timeout.
- bright_est  out  8  latest brightness estimate.
- rd_idx  in  3  frame buffer read index.
- rd_seg  out  8  frame buffer segments, 1-cycle read latency.
- rd_bright  out  8  per-character brightness, 1-cycle read latency.

Behaviour:
- Reset (rst_n low, asynchronous):
  - word_valid, scan_done, err_pulse = 0; err_code = 00.
  - word_data, char_idx, bright_est = 0.
  - Frame buffer, shift register, bit counter, timeout counter and synchronizers all clear.
  - rd_seg and rd_bright = 0.
- Synchronization: each input passes SYNC_STAGES flops. Edges are detected on the last two stages, giving a fixed latency of SYNC_STAGES+1 cycles from pin to event.
- SCLK rising edge:
  - sh <= {DOUT_sync, sh[15:1]}.
  - bit_cnt increments, saturating at 31.
  - Timeout counter clears.
- After exactly 16 shifts, sh equals the transmitted word: bit0 = SEG A, bit15 = CA7.
- RCLK rising edge (evaluated the same cycle; a simultaneous SCLK edge is applied first):
  - If bit_cnt==16 and sh[15:8] is one-hot:
    - word_data <= sh.
    - char_idx <= onehot position.
    - buffer[char_idx].seg <= sh[7:0].
    - buffer[char_idx].bright <= bright_est.
    - word_valid pulses the next cycle.
  - If bit_cnt!=16: err_code 01, err_pulse.
  - If bit_cnt==16 and CA is not one-hot (including zero): err_code 10, err_pulse. Buffer unchanged.
  - In all cases bit_cnt <= 0.
  - RCLK with bit_cnt==0 is ignored silently (idle latch, driver startup).
- scan_done: pulses together with word_valid when char_idx==7 and the previous good char_idx was 6.
- Timeout:
  - The timeout counter runs while bit_cnt!=0.
  - When it reaches TIMEOUT_CYC: err_code 11, err_pulse, bit_cnt <= 0, sh <= 0.
- err_code holds its last error until the next error or reset.
- Brightness measurement:
  - Free-running window counter over 2*DIMMING_STEPS cycles.
  - on_cnt counts cycles with OE_sync==0.
  - At window wrap: bright_est <= min(on_cnt>>1, DIMMING_STEPS-1), and on_cnt <= 0 (or 1 if active that cycle).
  - The driver's PWM is on for 2*b cycles per 512, so the estimate equals b exactly for a steady input.
- en low: bit_cnt, sh, timeout and window counters clear; no pulses are emitted; buffer contents and outputs hold.
- Reading rd_idx: rd_seg and rd_bright are registered from buffer[rd_idx] one cycle later. A write and a read to the same index in the same cycle returns the new value (write-first).

Test Plan:
- Shift word 0x043F LSB-first with 16 SCLK pulses, then RCLK -> word_valid once, word_data=0x043F, char_idx=2; rd_idx=2 gives rd_seg=0x3F.
- Eight consecutive words with CA 0x01..0x80 and SEG 0x10..0x17 -> eight word_valid pulses and scan_done on the last; buffer[i]=0x10+i.
- 15 SCLKs then RCLK -> err_code=01, buffer unchanged. 16 SCLKs with CA=0x05 -> err_code=10. 16 SCLKs with CA=0x00 -> err_code=10.
- 7 SCLKs then no activity for 4096 cycles -> err_code=11, err_pulse. A following good 16-bit word is captured correctly.
- ~OE low 200 of every 512 cycles -> bright_est=100 after the second window. Always high -> 0. Low 510 of 512 -> 255.
- Assert rst_n low midway through a word (bit 9) -> all outputs 0 immediately. After release, a full word is captured with no error.

Source files
------------

// File: rtl/sandpiper_7seg_scan_capture_if.sv
// Serial lines feeding the cascaded 74HCS596 pair, as seen by the scan-capture block.
interface sandpiper_7seg_scan_capture_if;
    logic SCLK_IN;
    logic DOUT_IN;
    logic RCLK_IN;
    logic OE_IN;

    modport master (output SCLK_IN, output DOUT_IN, output RCLK_IN, output OE_IN);
    modport slave  (input  SCLK_IN, input  DOUT_IN, input  RCLK_IN, input  OE_IN);
endinterface

// File: rtl/sandpiper_7seg_scan_capture.sv
// Reconstructs {CA,SEG} words from the 7-segment serial driver lines, keeps a per-character
// frame buffer of segments and brightness, and estimates brightness from the ~OE duty cycle.
module sandpiper_7seg_scan_capture #(
    parameter int SEG_CT        = 8,
    parameter int CAN_CT        = 8,
    parameter int DIMMING_STEPS = 256,
    parameter int TIMEOUT_CYC   = 4096,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                             sys_clk,
    input  logic                             rst_n,
    input  logic                             en,
    sandpiper_7seg_scan_capture_if.slave     ser,
    output logic                             word_valid,
    output logic [SEG_CT+CAN_CT-1:0]         word_data,
    output logic [$clog2(CAN_CT)-1:0]        char_idx,
    output logic                             scan_done,
    output logic                             err_pulse,
    output logic [1:0]                       err_code,
    output logic [$clog2(DIMMING_STEPS)-1:0] bright_est,
    input  logic [$clog2(CAN_CT)-1:0]        rd_idx,
    output logic [SEG_CT-1:0]                rd_seg,
    output logic [$clog2(DIMMING_STEPS)-1:0] rd_bright
);
    localparam int W     = SEG_CT + CAN_CT;
    localparam int IDX_W = $clog2(CAN_CT);
    localparam int BR_W  = $clog2(DIMMING_STEPS);
    localparam int WIN_W = BR_W + 1;
    localparam int ON_W  = WIN_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_BITS    = 2'b01,
        ERR_CA      = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    typedef struct packed {
        logic [SEG_CT-1:0] seg;
        logic [BR_W-1:0]   bright;
    } fb_entry_t;

    function automatic logic [IDX_W-1:0] onehot_pos(input logic [CAN_CT-1:0] v);
        onehot_pos = '0;
        for (int i = 0; i < CAN_CT; i++) begin
            if (v[i]) onehot_pos = IDX_W'(i);
        end
    endfunction

    // SCLK/RCLK carry one extra history flop so edges are seen on the last two stages.
    logic [SYNC_STAGES:0]   sclk_q, sclk_d, rclk_q, rclk_d;
    logic [SYNC_STAGES-1:0] dout_q, dout_d, oe_q, oe_d;

    logic [W-1:0]     sh_q, sh_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
    logic [BR_W-1:0]  bright_q, bright_d;
    logic [W-1:0]     word_data_q, word_data_d;
    logic [IDX_W-1:0] char_idx_q, char_idx_d;
    logic             word_valid_q, word_valid_d;
    logic             scan_done_q, scan_done_d;
    logic             err_pulse_q, err_pulse_d;
    err_e             err_code_q, err_code_d;
    fb_entry_t        fb_q [CAN_CT];
    fb_entry_t        fb_d [CAN_CT];
    fb_entry_t        rd_q, rd_d;

    logic              sclk_rise, rclk_rise, dout_s, oe_on;
    logic [W-1:0]      sh_cur;
    logic [CAN_CT-1:0] ca;
    logic              ca_ok;
    logic [IDX_W-1:0]  ca_idx;

    assign sclk_rise = en & sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign rclk_rise = en & rclk_q[SYNC_STAGES-1] & ~rclk_q[SYNC_STAGES];
    assign dout_s    = dout_q[SYNC_STAGES-1];
    assign oe_on     = ~oe_q[SYNC_STAGES-1];

    // A latch edge in the same cycle as a shift edge sees the shifted word.
    assign sh_cur = sclk_rise ? {dout_s, sh_q[W-1:1]} : sh_q;
    assign ca     = sh_cur[W-1:SEG_CT];
    assign ca_ok  = (ca != '0) && ((ca & (ca - 1'b1)) == '0);
    assign ca_idx = onehot_pos(ca);

    always_comb begin
        // NOTE: every variable receives a default first so no path leaves it unassigned (no latch).
        sclk_d       = {sclk_q[SYNC_STAGES-1:0], ser.SCLK_IN};
        rclk_d       = {rclk_q[SYNC_STAGES-1:0], ser.RCLK_IN};
        dout_d       = {dout_q[SYNC_STAGES-2:0], ser.DOUT_IN};
        oe_d         = {oe_q[SYNC_STAGES-2:0], ser.OE_IN};
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        win_cnt_d    = win_cnt_q + 1'b1;
        on_cnt_d     = on_cnt_q + ON_W'(oe_on);
        bright_d     = bright_q;
        word_data_d  = word_data_q;
        char_idx_d   = char_idx_q;
        word_valid_d = 1'b0;
        scan_done_d  = 1'b0;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        fb_d         = fb_q;

        if (!en) begin
            sh_d      = '0;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            win_cnt_d = '0;
            on_cnt_d  = '0;
        end else begin
            if (sclk_rise) begin
                sh_d      = sh_cur;
                bit_cnt_d = (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
                to_cnt_d  = '0;
            end else if (bit_cnt_q != '0) begin
                if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    bit_cnt_d   = '0;
                    sh_d        = '0;
                    to_cnt_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            // A latch with nothing shifted is the driver idling and is ignored.
            if (rclk_rise && bit_cnt_d != '0) begin
                if (bit_cnt_d != 5'(W)) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_BITS;
                end else if (!ca_ok) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_CA;
                end else begin
                    word_data_d        = sh_cur;
                    char_idx_d         = ca_idx;
                    fb_d[ca_idx].seg    = sh_cur[SEG_CT-1:0];
                    fb_d[ca_idx].bright = bright_q;
                    word_valid_d       = 1'b1;
                    scan_done_d        = (ca_idx == IDX_W'(CAN_CT - 1)) &&
                                         (char_idx_q == IDX_W'(CAN_CT - 2));
                end
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end

            // Window wrap: the wrap cycle's own ~OE sample opens the next window.
            if (win_cnt_q == '1) begin
                if (on_cnt_q >= ON_W'(2 * DIMMING_STEPS)) bright_d = '1;
                else                                      bright_d = BR_W'(on_cnt_q >> 1);
                on_cnt_d = ON_W'(oe_on);
            end
        end

        rd_d = fb_d[rd_idx];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q       <= '0;
            rclk_q       <= '0;
            dout_q       <= '0;
            oe_q         <= '0;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            win_cnt_q    <= '0;
            on_cnt_q     <= '0;
            bright_q     <= '0;
            word_data_q  <= '0;
            char_idx_q   <= '0;
            word_valid_q <= 1'b0;
            scan_done_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            rd_q         <= '0;
            // NOTE: the frame buffer is tiny and must read as blank after reset, so it is built from resettable flops.
            for (int i = 0; i < CAN_CT; i++) fb_q[i] <= '0;
        end else begin
            sclk_q       <= sclk_d;
            rclk_q       <= rclk_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            win_cnt_q    <= win_cnt_d;
            on_cnt_q     <= on_cnt_d;
            bright_q     <= bright_d;
            word_data_q  <= word_data_d;
            char_idx_q   <= char_idx_d;
            word_valid_q <= word_valid_d;
            scan_done_q  <= scan_done_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            rd_q         <= rd_d;
            for (int i = 0; i < CAN_CT; i++) fb_q[i] <= fb_d[i];
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign char_idx   = char_idx_q;
    assign scan_done  = scan_done_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign bright_est = bright_q;
    assign rd_seg     = rd_q.seg;
    assign rd_bright  = rd_q.bright;
endmodule

// File: tb/tb_sandpiper_7seg_scan_capture.sv
// Scoreboard bench for the 7-segment scan capture: drives the serial lines and checks
// captured words, error codes, frame buffer reads and brightness estimates.
module tb_sandpiper_7seg_scan_capture;
    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic [2:0]  rd_idx  = 3'd0;
    logic        word_valid, scan_done, err_pulse;
    logic [15:0] word_data;
    logic [2:0]  char_idx;
    logic [1:0]  err_code;
    logic [7:0]  bright_est, rd_seg, rd_bright;

    sandpiper_7seg_scan_capture_if ser_if ();

    sandpiper_7seg_scan_capture dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .en         (en),
        .ser        (ser_if),
        .word_valid (word_valid),
        .word_data  (word_data),
        .char_idx   (char_idx),
        .scan_done  (scan_done),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .bright_est (bright_est),
        .rd_idx     (rd_idx),
        .rd_seg     (rd_seg),
        .rd_bright  (rd_bright)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  idx;
        logic        scan;
    } wrec_t;

    wrec_t      exp_q[$];
    wrec_t      obs_q[$];
    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         err_seen = 0;
    logic [7:0] m_seg [8];
    logic [7:0] m_br  [8];
    int         m_prev = 0;

    // Monitor: record every captured word and count error pulses.
    always @(negedge sys_clk) begin
        if (word_valid) obs_q.push_back(wrec_t'({word_data, char_idx, scan_done}));
        if (err_pulse) err_seen++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ser_if.DOUT_IN = w[i];
            cycles(3);
            ser_if.SCLK_IN = 1'b1;
            cycles(3);
            ser_if.SCLK_IN = 1'b0;
            cycles(3);
        end
    endtask

    task automatic latch();
        ser_if.RCLK_IN = 1'b1;
        cycles(3);
        ser_if.RCLK_IN = 1'b0;
        cycles(3);
    endtask

    task automatic send_word(input logic [15:0] w);
        shift_bits(w, 16);
        latch();
    endtask

    // Reference model: which character a good word lights, and whether it closes a scan.
    task automatic push_good(input logic [15:0] w, input logic [7:0] br);
        wrec_t r;
        int    idx = 0;
        for (int i = 0; i < 8; i++) if (w[8+i]) idx = i;
        r.data = w;
        r.idx  = 3'(idx);
        r.scan = (idx == 7) && (m_prev == 6);
        m_seg[idx] = w[7:0];
        m_br[idx]  = br;
        m_prev     = idx;
        exp_q.push_back(r);
    endtask

    task automatic wait_words(output bit ok);
        int budget = 300;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            cycles(1);
            budget--;
        end
        cycles(5);
        ok = (obs_q.size() == exp_q.size());
    endtask

    task automatic read_fb(input int idx, output logic [7:0] seg, output logic [7:0] br);
        rd_idx = 3'(idx);
        cycles(1);
        seg = rd_seg;
        br  = rd_bright;
    endtask

    task automatic oe_pattern(input int low, input int periods);
        for (int p = 0; p < periods; p++) begin
            if (low > 0) begin
                ser_if.OE_IN = 1'b0;
                cycles(low);
            end
            if (low < 512) begin
                ser_if.OE_IN = 1'b1;
                cycles(512 - low);
            end
        end
    endtask

    task automatic test_reset();
        cycles(3);
        n_cmp++;
        if ({word_valid, scan_done, err_pulse, err_code} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 00000", {word_valid, scan_done, err_pulse, err_code});
        end
        n_cmp++;
        if (word_data !== 16'h0 || char_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_word: got data=%h idx=%0d required 0000/0", word_data, char_idx);
        end
        n_cmp++;
        if (bright_est !== 8'd0 || rd_seg !== 8'd0 || rd_bright !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_bright_rd: got bright=%0d seg=%h rbr=%0d required 0", bright_est, rd_seg, rd_bright);
        end
    endtask

    task automatic test_single_word();
        bit ok; wrec_t e, o; logic [7:0] s, b;
        int e0 = err_seen;
        push_good(16'h043F, 8'd0);
        send_word(16'h043F);
        wait_words(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single_word: got %h/%0d/%b required %h/%0d/%b", o.data, o.idx, o.scan, e.data, e.idx, e.scan);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++;
        if (err_seen != e0 || err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL single_noerr: got %0d pulses code=%b required 0 pulses code=00", err_seen - e0, err_code);
        end
        read_fb(2, s, b);
        n_cmp++;
        if (s !== 8'h3F) begin
            n_bad++;
            $display("FAIL single_rd_seg: got %h required 3f", s);
        end
    endtask

    task automatic test_scan();
        bit ok; wrec_t e, o; logic [7:0] s, b;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w = {8'(1 << i), 8'(8'h10 + i)};
            push_good(w, 8'd0);
            send_word(w);
        end
        wait_words(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL scan_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL scan_word: got %h/%0d/%b required %h/%0d/%b", o.data, o.idx, o.scan, e.data, e.idx, e.scan);
            end
        end
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 8; i++) begin
            read_fb(i, s, b);
            n_cmp++;
            if (s !== m_seg[i]) begin
                n_bad++;
                $display("FAIL scan_buf[%0d]: got %h required %h", i, s, m_seg[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [7:0] s, b;
        int e0 = err_seen;
        shift_bits(16'h01AA, 15);
        latch();
        cycles(2);
        n_cmp++;
        if (err_seen != e0 + 1 || err_code !== 2'b01) begin
            n_bad++;
            $display("FAIL err_bitcount: got %0d pulses code=%b required 1 pulse code=01", err_seen - e0, err_code);
        end
        send_word(16'h05AA);
        cycles(2);
        n_cmp++;
        if (err_seen != e0 + 2 || err_code !== 2'b10) begin
            n_bad++;
            $display("FAIL err_ca_multi: got %0d pulses code=%b required 2 pulses code=10", err_seen - e0, err_code);
        end
        send_word(16'h00AA);
        cycles(2);
        n_cmp++;
        if (err_seen != e0 + 3 || err_code !== 2'b10) begin
            n_bad++;
            $display("FAIL err_ca_zero: got %0d pulses code=%b required 3 pulses code=10", err_seen - e0, err_code);
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL err_no_word: got %0d words required 0", obs_q.size());
        end
        obs_q.delete();
        for (int i = 0; i < 8; i++) begin
            read_fb(i, s, b);
            n_cmp++;
            if (s !== m_seg[i]) begin
                n_bad++;
                $display("FAIL err_buf[%0d]: got %h required %h", i, s, m_seg[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok; wrec_t e, o; logic [7:0] s, b;
        int e0 = err_seen;
        int waited = 0;
        shift_bits(16'h0155, 7);
        while (err_seen == e0 && waited < 6000) begin
            cycles(1);
            waited++;
        end
        n_cmp++;
        if (err_seen != e0 + 1 || err_code !== 2'b11) begin
            n_bad++;
            $display("FAIL timeout_err: got %0d pulses code=%b required 1 pulse code=11", err_seen - e0, err_code);
        end
        n_cmp++;
        if (waited < 4085 || waited > 4100) begin
            n_bad++;
            $display("FAIL timeout_delay: got %0d cycles required 4085..4100", waited);
        end
        push_good(16'h2055, 8'd0);
        send_word(16'h2055);
        wait_words(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout_recover_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL timeout_recover: got %h/%0d/%b required %h/%0d/%b", o.data, o.idx, o.scan, e.data, e.idx, e.scan);
            end
        end
        exp_q.delete(); obs_q.delete();
        read_fb(5, s, b);
        n_cmp++;
        if (s !== 8'h55) begin
            n_bad++;
            $display("FAIL timeout_rd_seg: got %h required 55", s);
        end
    endtask

    task automatic test_brightness();
        bit ok; wrec_t e, o; logic [7:0] s, b;
        oe_pattern(200, 4);
        n_cmp++;
        if (bright_est !== 8'd100) begin
            n_bad++;
            $display("FAIL bright_200: got %0d required 100", bright_est);
        end
        push_good(16'h084F, 8'd100);
        fork
            oe_pattern(200, 2);
            send_word(16'h084F);
        join
        wait_words(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bright_word_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL bright_word: got %h/%0d/%b required %h/%0d/%b", o.data, o.idx, o.scan, e.data, e.idx, e.scan);
            end
        end
        exp_q.delete(); obs_q.delete();
        read_fb(3, s, b);
        n_cmp++;
        if (s !== 8'h4F || b !== m_br[3]) begin
            n_bad++;
            $display("FAIL bright_rd: got seg=%h br=%0d required seg=4f br=%0d", s, b, m_br[3]);
        end
        oe_pattern(0, 4);
        n_cmp++;
        if (bright_est !== 8'd0) begin
            n_bad++;
            $display("FAIL bright_off: got %0d required 0", bright_est);
        end
        oe_pattern(510, 4);
        n_cmp++;
        if (bright_est !== 8'd255) begin
            n_bad++;
            $display("FAIL bright_510: got %0d required 255", bright_est);
        end
        oe_pattern(512, 4);
        n_cmp++;
        if (bright_est !== 8'd255) begin
            n_bad++;
            $display("FAIL bright_clamp: got %0d required 255", bright_est);
        end
        ser_if.OE_IN = 1'b1;
    endtask

    task automatic test_reset_midword();
        bit ok; wrec_t e, o; logic [7:0] s, b;
        int e0;
        shift_bits(16'h1234, 9);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (word_data !== 16'h0 || char_idx !== 3'd0 || err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL midreset_word: got data=%h idx=%0d code=%b required 0", word_data, char_idx, err_code);
        end
        n_cmp++;
        if (bright_est !== 8'd0 || rd_seg !== 8'd0 || rd_bright !== 8'd0) begin
            n_bad++;
            $display("FAIL midreset_bright_rd: got bright=%0d seg=%h rbr=%0d required 0", bright_est, rd_seg, rd_bright);
        end
        cycles(3);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_seg[i] = 8'h00;
            m_br[i]  = 8'h00;
        end
        m_prev = 0;
        cycles(5);
        e0 = err_seen;
        push_good(16'h40F0, 8'd0);
        send_word(16'h40F0);
        wait_words(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d words required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL midreset_word_after: got %h/%0d/%b required %h/%0d/%b", o.data, o.idx, o.scan, e.data, e.idx, e.scan);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++;
        if (err_seen != e0 || err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL midreset_noerr: got %0d pulses code=%b required 0 pulses code=00", err_seen - e0, err_code);
        end
        read_fb(6, s, b);
        n_cmp++;
        if (s !== 8'hF0) begin
            n_bad++;
            $display("FAIL midreset_rd6: got %h required f0", s);
        end
        read_fb(2, s, b);
        n_cmp++;
        if (s !== m_seg[2]) begin
            n_bad++;
            $display("FAIL midreset_rd2_cleared: got %h required %h", s, m_seg[2]);
        end
    endtask

    initial begin
        ser_if.SCLK_IN = 1'b0;
        ser_if.DOUT_IN = 1'b0;
        ser_if.RCLK_IN = 1'b0;
        ser_if.OE_IN   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_seg[i] = 8'h00;
            m_br[i]  = 8'h00;
        end
        test_reset();
        rst_n = 1'b1;
        en    = 1'b1;
        cycles(5);
        test_single_word();
        test_scan();
        test_errors();
        test_timeout();
        test_brightness();
        test_reset_midword();
        cycles(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
